oam_dma: RTL and testbench

Sprite-DMA engine between the `cpu` core and the system bus. It watches CPU writes and, on a write to $4014, halts the CPU through its `ready` input. It then copies the 256-byte page `{data,$00..$FF}` to the PPU OAM data port $2004 as alternating read/write bus cycles, and returns the bus to the CPU when the copy is done. When idle it is a transparent pass-through for the CPU's address, data and write signals.

---
 rtl/oam_dma_if.sv | 32 +++
 rtl/oam_dma.sv | 109 ++++++++++
 tb/tb_oam_dma.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/oam_dma_if.sv
// ============================================================================
//  Module      : oam_dma_if
//  Description : CPU-side and system-bus-side signals of the sprite-DMA engine.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

interface oam_dma_if;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_d_out;
    logic        cpu_write;
    logic        cpu_ready;
    logic [15:0] bus_addr;
    logic [7:0]  bus_d_out;
    logic        bus_write;
    logic [7:0]  bus_d_in;
    logic        dma_active;

    // The DMA engine sits between CPU and bus.
    modport slave (
        input  cpu_addr, cpu_d_out, cpu_write, bus_d_in,
        output cpu_ready, bus_addr, bus_d_out, bus_write, dma_active
    );

    // CPU plus memory side.
    modport master (
        output cpu_addr, cpu_d_out, cpu_write, bus_d_in,
        input  cpu_ready, bus_addr, bus_d_out, bus_write, dma_active
    );
endinterface

`default_nettype wire

// File: rtl/oam_dma.sv
// ============================================================================
//  Module      : oam_dma
//  Description : Sprite-DMA engine; on a CPU write to TRIGGER_ADDR it halts the
//                CPU and copies one 256-byte page to OAM_ADDR.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module oam_dma #(
    parameter logic [15:0] TRIGGER_ADDR = 16'h4014,
    parameter logic [15:0] OAM_ADDR     = 16'h2004
) (
    input  wire logic   clk,
    input  wire logic   reset,
    oam_dma_if.slave    bus
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_HALT  = 3'd1;
    localparam logic [2:0] c_ALIGN = 3'd2;
    localparam logic [2:0] c_READ  = 3'd3;
    localparam logic [2:0] c_WRITE = 3'd4;

    logic [2:0]  r_state;
    logic [2:0]  w_state_nxt;
    logic [7:0]  r_page;
    logic [7:0]  r_cnt;
    logic        r_parity;
    logic        w_trigger;

    logic        w_cpu_ready;
    logic        w_dma_active;
    logic [15:0] w_bus_addr;
    logic [7:0]  w_bus_d_out;
    logic        w_bus_write;

    assign w_trigger = bus.cpu_write && (bus.cpu_addr == TRIGGER_ADDR);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (w_trigger) w_state_nxt = c_HALT;
            // An odd parity in the dummy cycle needs one extra cycle to realign.
            c_HALT:  w_state_nxt = r_parity ? c_ALIGN : c_READ;
            c_ALIGN: w_state_nxt = c_READ;
            c_READ:  w_state_nxt = c_WRITE;
            c_WRITE: w_state_nxt = (r_cnt == 8'hFF) ? c_IDLE : c_READ;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= c_IDLE;
            r_page   <= 8'h00;
            r_cnt    <= 8'h00;
            r_parity <= 1'b0;
        end else begin
            r_parity <= ~r_parity;
            r_state  <= w_state_nxt;
            if (r_state == c_IDLE && w_trigger) begin
                r_page <= bus.cpu_d_out;
                r_cnt  <= 8'h00;
            end else if (r_state == c_WRITE) begin
                r_cnt  <= r_cnt + 8'd1;
            end
        end
    end

    always_comb begin
        w_cpu_ready  = 1'b1;
        w_dma_active = 1'b0;
        w_bus_addr   = bus.cpu_addr;
        w_bus_d_out  = bus.cpu_d_out;
        w_bus_write  = bus.cpu_write;
        case (r_state)
            c_HALT, c_ALIGN: begin
                w_cpu_ready  = 1'b0;
                w_dma_active = 1'b1;
                w_bus_write  = 1'b0;
            end
            c_READ: begin
                w_cpu_ready  = 1'b0;
                w_dma_active = 1'b1;
                w_bus_addr   = {r_page, r_cnt};
                w_bus_write  = 1'b0;
            end
            c_WRITE: begin
                // Byte read in the previous cycle arrives on bus_d_in now.
                w_cpu_ready  = 1'b0;
                w_dma_active = 1'b1;
                w_bus_addr   = OAM_ADDR;
                w_bus_d_out  = bus.bus_d_in;
                w_bus_write  = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.cpu_ready  = w_cpu_ready;
    assign bus.dma_active = w_dma_active;
    assign bus.bus_addr   = w_bus_addr;
    assign bus.bus_d_out  = w_bus_d_out;
    // Keep the bus quiet for the whole time reset is held.
    assign bus.bus_write  = w_bus_write & reset;

endmodule

`default_nettype wire

// File: tb/tb_oam_dma.sv
// ============================================================================
//  Module      : tb_oam_dma
//  Description : Randomized scoreboard bench for the sprite-DMA engine.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_oam_dma;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    oam_dma_if bif();

    oam_dma dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
        int          cyc;
    } exp_t;

    exp_t        sb_q[$];
    int          len_q[$];
    logic [7:0]  mem [0:65535];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          wr_cnt = 0;
    int          lowcnt = 0;
    logic        tb_par;
    logic [15:0] prev_addr = 16'h0000;

    // Synchronous memory: data for this cycle's address appears next cycle.
    always @(posedge clk) bif.bus_d_in <= mem[bif.bus_addr];
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk or negedge reset)
        if (!reset) tb_par <= 1'b0;
        else        tb_par <= ~tb_par;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: a trigger in cycle T copies the page in order, the
    // first OAM write lands 3 cycles later (+1 when alignment is needed).
    task automatic start_model(input logic [7:0] page, input int t, input logic par_t);
        int al;
        al = par_t ? 0 : 1;
        for (int i = 0; i < 256; i++) begin
            exp_t e;
            e.addr = {page, 8'(i)};
            e.data = mem[{page, 8'(i)}];
            e.cyc  = t + 3 + al + 2 * i;
            sb_q.push_back(e);
        end
        len_q.push_back(513 + al);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            lowcnt = 0;
        end else begin
            if (bif.bus_write && bif.bus_addr == 16'h2004) begin
                wr_cnt++;
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_oam_write: got data %0h expected no write (cycle %0d)",
                             bif.bus_d_out, cyc);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("oam_src_addr", 32'(prev_addr), 32'(e.addr));
                    chk("oam_data", 32'(bif.bus_d_out), 32'(e.data));
                    chk("oam_cycle", 32'(cyc), 32'(e.cyc));
                    chk("oam_dma_active", 32'(bif.dma_active), 32'd1);
                end
            end
            if (!bif.cpu_ready) begin
                lowcnt++;
            end else if (lowcnt > 0) begin
                if (len_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_halt: got %0d halted cycles expected none", lowcnt);
                end else begin
                    chk("halt_len", 32'(lowcnt), 32'(len_q.pop_front()));
                end
                chk("release_dma_active", 32'(bif.dma_active), 32'd0);
                chk("release_passthru", 32'(bif.bus_addr), 32'(bif.cpu_addr));
                lowcnt = 0;
            end
            prev_addr = bif.bus_addr;
        end
    end

    function automatic logic [15:0] safe_addr();
        logic [15:0] a;
        a = 16'($urandom);
        while (a == 16'h4014 || a == 16'h2004) a = 16'($urandom);
        return a;
    endfunction

    task automatic drive_rand();
        bif.cpu_addr  = safe_addr();
        bif.cpu_d_out = 8'($urandom);
        bif.cpu_write = 1'($urandom_range(0, 1));
    endtask

    task automatic idle_op(input logic [15:0] a, input logic [7:0] d, input logic w);
        @(posedge clk); #1;
        bif.cpu_addr = a; bif.cpu_d_out = d; bif.cpu_write = w;
        @(negedge clk);
        chk("idle_addr", 32'(bif.bus_addr), 32'(a));
        chk("idle_dout", 32'(bif.bus_d_out), 32'(d));
        chk("idle_write", 32'(bif.bus_write), 32'(w));
        chk("idle_ready", 32'(bif.cpu_ready), 32'd1);
        chk("idle_active", 32'(bif.dma_active), 32'd0);
    endtask

    task automatic idle_rand(input int n);
        for (int i = 0; i < n; i++) idle_op(safe_addr(), 8'($urandom), 1'($urandom_range(0, 1)));
    endtask

    // want_par < 0 means trigger on whatever parity comes up.
    task automatic trigger(input logic [7:0] page, input int want_par);
        @(posedge clk); #1;
        while (want_par >= 0 && tb_par != 1'(want_par)) begin
            @(posedge clk); #1;
        end
        bif.cpu_addr = 16'h4014; bif.cpu_d_out = page; bif.cpu_write = 1'b1;
        start_model(page, cyc, tb_par);
        @(posedge clk); #1;
        drive_rand();
    endtask

    task automatic wait_done(input bit retrig);
        int n;
        n = 0;
        while ((sb_q.size() != 0 || len_q.size() != 0) && n < 3000) begin
            @(posedge clk); #1;
            if (retrig && n >= 40 && n < 60) begin
                bif.cpu_addr = 16'h4014; bif.cpu_d_out = 8'h07; bif.cpu_write = 1'b1;
            end else begin
                drive_rand();
            end
            n++;
        end
        chk("xfer_complete", 32'(n < 3000), 32'd1);
    endtask

    initial begin
        int n;
        int base;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i);

        reset = 1'b0;
        bif.cpu_addr = 16'h1234; bif.cpu_d_out = 8'hA5; bif.cpu_write = 1'b1;
        #13;
        chk("rst_ready", 32'(bif.cpu_ready), 32'd1);
        chk("rst_active", 32'(bif.dma_active), 32'd0);
        chk("rst_write", 32'(bif.bus_write), 32'd0);
        chk("rst_addr", 32'(bif.bus_addr), 32'h1234);
        chk("rst_dout", 32'(bif.bus_d_out), 32'hA5);
        @(posedge clk); #1;
        bif.cpu_write = 1'b0;
        reset = 1'b1;

        idle_op(16'h0300, 8'h55, 1'b1);
        idle_op(16'h8000, 8'h00, 1'b0);
        idle_rand(4);

        trigger(8'h02, 1);           // even: no ALIGN
        wait_done(1'b0);
        idle_rand(3);
        trigger(8'h02, 0);           // odd: ALIGN inserted
        wait_done(1'b0);
        idle_rand(3);

        trigger(8'h03, -1);          // retrigger attempts must be ignored
        wait_done(1'b1);
        idle_rand(3);

        // Reset in the middle of a transfer.
        base = wr_cnt;
        trigger(8'($urandom), -1);
        n = 0;
        while (wr_cnt < base + 100 && n < 1000) begin
            @(negedge clk); #1;
            n++;
        end
        chk("reset_wait", 32'(n < 1000), 32'd1);
        reset = 1'b0;
        #1;
        chk("midrst_ready", 32'(bif.cpu_ready), 32'd1);
        chk("midrst_write", 32'(bif.bus_write), 32'd0);
        chk("midrst_active", 32'(bif.dma_active), 32'd0);
        sb_q.delete();
        len_q.delete();
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        idle_rand(10);

        trigger(8'h04, -1);
        wait_done(1'b0);
        idle_rand(3);

        trigger(8'hFF, -1);          // top page: no wrap into page 00
        wait_done(1'b0);
        idle_rand(3);

        for (int k = 0; k < 3; k++) begin
            trigger(8'($urandom), -1);
            wait_done(1'b0);
            idle_rand($urandom_range(1, 6));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

`default_nettype wire
